ritc_phase_scanner_engine: RTL and testbench

//  Execution side of the RITC phase-scanner command interface. Latches argument/command strobes

---
 rtl/ritc_phase_scanner_engine_if.sv | 37 +++
 rtl/ritc_phase_scanner_engine.sv | 198 +++++++++++++++++++
 tb/tb_ritc_phase_scanner_engine.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ritc_phase_scanner_engine_if.sv
// Command/result bus between the RITC register front-end (master) and the phase-scanner engine (slave).
// The optional RITC_SCANNER_SYNC_EN build does not change this bus.
interface ritc_phase_scanner_engine_if #(
    parameter int NCH   = 3,
    parameter int DLY_W = 5
);
    // Handshake: there is no back-pressure. cmd_wr_i and argument_wr_i are single-cycle strobes
    // that are taken on the rising edge where they are high. result_valid_o, servo_update_o and
    // delay_ld_o are single-cycle strobes. The data that goes with each output strobe is valid in
    // the same cycle and stays held until it is next written.
    logic [7:0]       select_i;
    logic [7:0]       cmd_i;
    logic             cmd_wr_i;
    logic [15:0]      argument_i;
    logic             argument_wr_i;
    logic [NCH-1:0]   sample_i;
    logic [DLY_W-1:0] delay_val_o;
    logic [NCH-1:0]   delay_ld_o;
    logic [15:0]      result_o;
    logic             result_valid_o;
    logic [15:0]      servo_o;
    logic             servo_update_o;
    logic             busy_o;
    logic [1:0]       state_o;

    modport master (
        output select_i, cmd_i, cmd_wr_i, argument_i, argument_wr_i, sample_i,
        input  delay_val_o, delay_ld_o, result_o, result_valid_o, servo_o, servo_update_o,
               busy_o, state_o
    );

    modport slave (
        input  select_i, cmd_i, cmd_wr_i, argument_i, argument_wr_i, sample_i,
        output delay_val_o, delay_ld_o, result_o, result_valid_o, servo_o, servo_update_o,
               busy_o, state_o
    );
endinterface

// File: rtl/ritc_phase_scanner_engine.sv
// RITC phase-scanner execution engine: loads delay taps, counts phase samples over a window (one-shot scan or servo).
// Define RITC_SCANNER_SYNC_EN to pass sample_i through a 2-flop synchronizer; the counting window then starts 2 cycles later.
module ritc_phase_scanner_engine #(
    parameter int NCH   = 3,
    parameter int DLY_W = 5
) (
    input  logic                         CLK,
    input  logic                         RST,
    ritc_phase_scanner_engine_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SERVO = 2'd2
    } state_t;

    localparam logic [7:0] CMD_NOP         = 8'h00;
    localparam logic [7:0] CMD_SET_DELAY   = 8'h01;
    localparam logic [7:0] CMD_SCAN        = 8'h02;
    localparam logic [7:0] CMD_SERVO_START = 8'h03;
    localparam logic [7:0] CMD_SERVO_STOP  = 8'h04;
    localparam logic [15:0] ERR_CODE       = 16'hDEAD;

    state_t           state_q;
    logic [15:0]      arg_q;
    logic [15:0]      run_arg_q;
    logic [15:0]      win_q;
    logic [16:0]      cnt_q;
    logic [NCH-1:0]   mask_q;
    logic [1:0]       skip_q;
    logic [DLY_W-1:0] delay_val_q;
    logic [NCH-1:0]   delay_ld_q;
    logic [15:0]      result_q;
    logic             result_valid_q;
    logic [15:0]      servo_q;
    logic             servo_update_q;

    logic [NCH-1:0]   sample_src;
    logic [1:0]       skip_init;

`ifdef RITC_SCANNER_SYNC_EN
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.sample_i;
            sync2_q <= sync1_q;
        end
    end

    assign sample_src = sync2_q;
    assign skip_init  = 2'd2;
`else
    assign sample_src = bus.sample_i;
    assign skip_init  = 2'd0;
`endif

    // A write in the same cycle as a command takes precedence over the stored argument.
    logic [15:0]    arg_eff;
    logic           sel_ok;
    logic [NCH-1:0] sel_mask;
    logic           hit;
    logic [16:0]    cnt_sum;
    logic [15:0]    cnt_sat;
    logic           stop_req;

    assign arg_eff  = bus.argument_wr_i ? bus.argument_i : arg_q;
    assign sel_ok   = (bus.select_i < 8'(NCH));
    assign sel_mask = sel_ok ? (NCH'(1) << bus.select_i) : '0;
    assign hit      = |(sample_src & mask_q);
    assign cnt_sum  = cnt_q + {16'd0, hit};
    assign cnt_sat  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    assign stop_req = bus.cmd_wr_i && (bus.cmd_i == CMD_SERVO_STOP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            arg_q          <= '0;
            run_arg_q      <= '0;
            win_q          <= '0;
            cnt_q          <= '0;
            mask_q         <= '0;
            skip_q         <= '0;
            delay_val_q    <= '0;
            delay_ld_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            servo_q        <= '0;
            servo_update_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            servo_update_q <= 1'b0;
            delay_ld_q     <= '0;
            if (bus.argument_wr_i) begin
                arg_q <= bus.argument_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_wr_i) begin
                        case (bus.cmd_i)
                            CMD_NOP, CMD_SERVO_STOP: begin
                            end
                            CMD_SET_DELAY: begin
                                result_valid_q <= 1'b1;
                                if (sel_ok) begin
                                    delay_val_q <= arg_eff[DLY_W-1:0];
                                    delay_ld_q  <= sel_mask;
                                    result_q    <= arg_eff;
                                end else begin
                                    result_q    <= ERR_CODE;
                                end
                            end
                            CMD_SCAN: begin
                                if (!sel_ok) begin
                                    result_q       <= ERR_CODE;
                                    result_valid_q <= 1'b1;
                                end else if (arg_eff == 16'd0) begin
                                    result_q       <= 16'd0;
                                    result_valid_q <= 1'b1;
                                end else begin
                                    state_q   <= ST_SCAN;
                                    mask_q    <= sel_mask;
                                    run_arg_q <= arg_eff;
                                    win_q     <= arg_eff;
                                    cnt_q     <= '0;
                                    skip_q    <= skip_init;
                                end
                            end
                            CMD_SERVO_START: begin
                                if (!sel_ok || (arg_eff == 16'd0)) begin
                                    result_q       <= ERR_CODE;
                                    result_valid_q <= 1'b1;
                                end else begin
                                    state_q   <= ST_SERVO;
                                    mask_q    <= sel_mask;
                                    run_arg_q <= arg_eff;
                                    win_q     <= arg_eff;
                                    cnt_q     <= '0;
                                    skip_q    <= skip_init;
                                end
                            end
                            default: begin
                                result_q       <= ERR_CODE;
                                result_valid_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_SCAN: begin
                    if (stop_req) begin
                        state_q <= ST_IDLE;
                    end else if (skip_q != 2'd0) begin
                        skip_q <= skip_q - 2'd1;
                    end else if (win_q == 16'd1) begin
                        result_q       <= cnt_sat;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end else begin
                        win_q <= win_q - 16'd1;
                        cnt_q <= cnt_sum;
                    end
                end
                ST_SERVO: begin
                    // Windows run back to back: the reload happens on the same edge as the update.
                    if (stop_req) begin
                        state_q <= ST_IDLE;
                    end else if (skip_q != 2'd0) begin
                        skip_q <= skip_q - 2'd1;
                    end else if (win_q == 16'd1) begin
                        servo_q        <= cnt_sat;
                        servo_update_q <= 1'b1;
                        win_q          <= run_arg_q;
                        cnt_q          <= '0;
                    end else begin
                        win_q <= win_q - 16'd1;
                        cnt_q <= cnt_sum;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.delay_val_o    = delay_val_q;
    assign bus.delay_ld_o     = delay_ld_q;
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = result_valid_q;
    assign bus.servo_o        = servo_q;
    assign bus.servo_update_o = servo_update_q;
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_ritc_phase_scanner_engine.sv
// Directed bench for ritc_phase_scanner_engine: expected results/servo values go into queues when commands are driven.
module tb_ritc_phase_scanner_engine;
    localparam int NCH   = 3;
    localparam int DLY_W = 5;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ritc_phase_scanner_engine_if #(.NCH(NCH), .DLY_W(DLY_W)) bus ();

    ritc_phase_scanner_engine #(.NCH(NCH), .DLY_W(DLY_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    // Scoreboard
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [15:0] srv_q[$];
    int          srv_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        int          c;
        if (!rst) begin
            chk("strobe_overlap", 32'(bus.result_valid_o & bus.servo_update_o), 32'd0);
            if (bus.result_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_valid", 32'(bus.result_valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    chk("result_value", 32'(bus.result_o), 32'(e));
                    chk("result_cycle", cyc, c);
                end
            end
            if (bus.servo_update_o) begin
                if (srv_q.size() == 0) begin
                    chk("unexpected_servo_update", 32'(bus.servo_update_o), 32'd0);
                end else begin
                    e = srv_q.pop_front();
                    c = srv_cyc_q.pop_front();
                    chk("servo_value", 32'(bus.servo_o), 32'(e));
                    chk("servo_cycle", cyc, c);
                end
            end
        end
    end

    // Driver tasks: each starts and ends 1ns after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_arg(input logic [15:0] a);
        bus.argument_i    = a;
        bus.argument_wr_i = 1'b1;
        step();
        bus.argument_wr_i = 1'b0;
    endtask

    task automatic issue(input logic [7:0] sel, input logic [7:0] cmd, input bit wr_arg,
                         input logic [15:0] a, input bit exp_res, input logic [15:0] exp_val,
                         input int lat, output int n);
        bus.select_i      = sel;
        bus.cmd_i         = cmd;
        bus.cmd_wr_i      = 1'b1;
        bus.argument_wr_i = wr_arg;
        bus.argument_i    = a;
        n = cyc;
        if (exp_res) begin
            exp_q.push_back(exp_val);
            exp_cyc_q.push_back(n + lat);
        end
        step();
        bus.cmd_wr_i      = 1'b0;
        bus.argument_wr_i = 1'b0;
        bus.select_i      = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || srv_q.size() != 0); i++) step();
        chk("drain_pending", exp_q.size() + srv_q.size(), 32'd0);
    endtask

    initial begin
        int          n;
        int          m;
        logic [15:0] pat;
        bus.select_i      = '0;
        bus.cmd_i         = '0;
        bus.cmd_wr_i      = 1'b0;
        bus.argument_i    = '0;
        bus.argument_wr_i = 1'b0;
        bus.sample_i      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_result", 32'(bus.result_o), 32'd0);
        chk("rst_result_valid", 32'(bus.result_valid_o), 32'd0);
        chk("rst_servo", 32'(bus.servo_o), 32'd0);
        chk("rst_servo_update", 32'(bus.servo_update_o), 32'd0);
        chk("rst_delay_val", 32'(bus.delay_val_o), 32'd0);
        chk("rst_delay_ld", 32'(bus.delay_ld_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        step();

        // SET_DELAY on channel 1
        write_arg(16'h0005);
        issue(8'd1, 8'h01, 1'b0, 16'h0, 1'b1, 16'h0005, 1, n);
        chk("set_delay_ld", 32'(bus.delay_ld_o), 32'b010);
        chk("set_delay_val", 32'(bus.delay_val_o), 32'd5);
        chk("set_delay_busy", 32'(bus.busy_o), 32'd0);
        step();
        chk("set_delay_ld_pulse", 32'(bus.delay_ld_o), 32'd0);
        chk("set_delay_val_hold", 32'(bus.delay_val_o), 32'd5);
        drain(10);

        // SCAN of 16 cycles on channel 0, 10 ones; the command cycle itself is not counted
        pat = 16'b1011_0110_1101_0011;
        write_arg(16'd16);
        bus.sample_i = {2'($urandom_range(0, 3)), 1'b1};
        issue(8'd0, 8'h02, 1'b0, 16'h0, 1'b1, 16'd10, 17, n);
        chk("scan_busy", 32'(bus.busy_o), 32'd1);
        for (int i = 0; i < 16; i++) begin
            bus.sample_i = {2'($urandom_range(0, 3)), pat[i]};
            step();
        end
        bus.sample_i = 3'b111;
        chk("scan_done_busy", 32'(bus.busy_o), 32'd0);
        drain(10);

        // SERVO with 8-cycle windows on channel 2
        write_arg(16'd8);
        bus.sample_i = {1'b1, 2'($urandom_range(0, 3))};
        issue(8'd2, 8'h03, 1'b0, 16'h0, 1'b0, 16'h0, 0, n);
        for (int k = 1; k <= 3; k++) begin
            srv_q.push_back(16'd8);
            srv_cyc_q.push_back(n + 1 + 8 * k);
        end
        chk("servo_busy", 32'(bus.busy_o), 32'd1);
        wait_until(n + 12);
        issue(8'd0, 8'h02, 1'b1, 16'd4, 1'b0, 16'h0, 0, m);
        chk("servo_ignores_scan", 32'(bus.busy_o), 32'd1);
        wait_until(n + 27);
        issue(8'd0, 8'h04, 1'b0, 16'h0, 1'b0, 16'h0, 0, m);
        chk("servo_stop_busy", 32'(bus.busy_o), 32'd0);
        chk("servo_hold", 32'(bus.servo_o), 32'd8);
        repeat (20) step();
        chk("servo_pending", srv_q.size(), 32'd0);

        // Error codes and zero-length scan
        issue(8'd0, 8'h7F, 1'b0, 16'h0, 1'b1, 16'hDEAD, 1, n);
        drain(10);
        write_arg(16'd20);
        issue(8'd5, 8'h02, 1'b0, 16'h0, 1'b1, 16'hDEAD, 1, n);
        chk("bad_sel_busy", 32'(bus.busy_o), 32'd0);
        drain(10);
        issue(8'd0, 8'h02, 1'b1, 16'd0, 1'b1, 16'h0000, 1, n);
        chk("scan_zero_busy", 32'(bus.busy_o), 32'd0);
        drain(10);
        issue(8'd0, 8'h03, 1'b0, 16'h0, 1'b1, 16'hDEAD, 1, n);
        chk("servo_zero_busy", 32'(bus.busy_o), 32'd0);
        drain(10);
        issue(8'd1, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 0, n);
        issue(8'd1, 8'h04, 1'b0, 16'h0, 1'b0, 16'h0, 0, n);
        repeat (3) step();
        chk("nop_busy", 32'(bus.busy_o), 32'd0);

        // Same-cycle argument write: new arg 3 wins over stored 100
        write_arg(16'd100);
        bus.sample_i = 3'b111;
        issue(8'd1, 8'h02, 1'b1, 16'd3, 1'b1, 16'd3, 4, n);
        drain(20);

        // Reset during a scan aborts it silently and clears arg
        write_arg(16'd50);
        issue(8'd0, 8'h02, 1'b0, 16'h0, 1'b0, 16'h0, 0, n);
        repeat (10) step();
        rst = 1'b1;
        step();
        chk("rst_mid_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_mid_result", 32'(bus.result_o), 32'd0);
        rst = 1'b0;
        repeat (60) step();
        issue(8'd0, 8'h02, 1'b0, 16'h0, 1'b1, 16'h0000, 1, n);
        chk("rst_arg_cleared_busy", 32'(bus.busy_o), 32'd0);
        drain(10);

        chk("final_result_q", exp_q.size(), 32'd0);
        chk("final_servo_q", srv_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
